// File: rtl/button_event_scheduler_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// btn_pkg: shared types and helpers for the button event scheduler.  Rev 1.0
// -----------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } chan_state_t;

  // Event-id width for a given channel count (channel count is always >= 2).
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_event_scheduler_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// button_event_scheduler_if: valid/ready event port toward the control unit. Rev 1.0
// -----------------------------------------------------------------------------
interface button_event_scheduler_if #(
  parameter int ID_W = 2
);
  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic            evt_repeat;

  modport master (
    output evt_valid,
    output evt_id,
    output evt_repeat,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    input  evt_repeat,
    output evt_ready
  );
endinterface
`default_nettype wire

// File: rtl/button_event_scheduler_channel.sv
`default_nettype none
// -----------------------------------------------------------------------------
// btn_channel: per-button sync, debounce, hold/repeat FSM and pending slot. Rev 1.0
// -----------------------------------------------------------------------------
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEB_N  = 2_000_000,
  parameter int DEB_W  = 21,
  parameter int HOLD_N = 50_000_000,
  parameter int REP_N  = 10_000_000,
  parameter int HOLD_W = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  input  logic grant_i,
  output logic btn_level_o,
  output logic pend_o,
  output logic pend_rep_o
);

  logic              sync1_q, sync2_q;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic              level_q, level_d;
  chan_state_t       state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              pend_q, pend_d;
  logic              pend_rep_q, pend_rep_d;
  logic              post, post_rep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_cnt_q  <= '0;
      level_q    <= 1'b0;
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      pend_q     <= 1'b0;
      pend_rep_q <= 1'b0;
    end else begin
      sync1_q    <= btn_raw_i;
      sync2_q    <= sync1_q;
      deb_cnt_q  <= deb_cnt_d;
      level_q    <= level_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      pend_q     <= pend_d;
      pend_rep_q <= pend_rep_d;
    end
  end

  // Symmetric debounce: any sample agreeing with the current level restarts the count.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    level_d   = level_q;
    if (sync2_q == level_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_W'(DEB_N - 1)) begin
      level_d   = sync2_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    post       = 1'b0;
    post_rep   = 1'b0;
    if (!level_q) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          post       = 1'b1;
          hold_cnt_d = '0;
          state_d    = HOLD;
        end
        HOLD: begin
          if (hold_cnt_q == HOLD_W'(HOLD_N - 1)) begin
            post       = 1'b1;
            post_rep   = 1'b1;
            hold_cnt_d = '0;
            state_d    = REPEAT;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (hold_cnt_q == HOLD_W'(REP_N - 1)) begin
            post       = 1'b1;
            post_rep   = 1'b1;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  // A post into a slot being granted this cycle refills it; into a full slot it is lost.
  always_comb begin
    pend_d     = pend_q;
    pend_rep_d = pend_rep_q;
    if (grant_i) begin
      pend_d     = 1'b0;
      pend_rep_d = 1'b0;
    end
    if (post && (!pend_q || grant_i)) begin
      pend_d     = 1'b1;
      pend_rep_d = post_rep;
    end
  end

  assign btn_level_o = level_q;
  assign pend_o      = pend_q;
  assign pend_rep_o  = pend_rep_q;

endmodule
`default_nettype wire

// File: rtl/button_event_scheduler.sv
`default_nettype none
// -----------------------------------------------------------------------------
// button_event_scheduler: debounced buttons to round-robin press/repeat events. Rev 1.0
// -----------------------------------------------------------------------------
module button_event_scheduler
  import btn_pkg::*;
#(
  parameter int NBTN   = 4,
  parameter int DEB_N  = 2_000_000,
  parameter int DEB_W  = 21,
  parameter int HOLD_N = 50_000_000,
  parameter int REP_N  = 10_000_000,
  parameter int HOLD_W = 26
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NBTN-1:0]               btn_raw_i,
  output logic [NBTN-1:0]               btn_level_o,
  button_event_scheduler_if.master      evt_if
);

  localparam int ID_W = id_w(NBTN);
  localparam logic [ID_W:0] NBTN_W = (ID_W + 1)'(NBTN);

  logic [NBTN-1:0] pend, pend_rep, grant_vec, rotated;
  logic            any_pend, load;
  logic [ID_W-1:0] sel_off, grant_id;
  logic [ID_W:0]   sum, nxt;

  logic            valid_q, valid_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            rep_q, rep_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  for (genvar i = 0; i < NBTN; i++) begin : g_chan
    btn_channel #(
      .DEB_N  (DEB_N),
      .DEB_W  (DEB_W),
      .HOLD_N (HOLD_N),
      .REP_N  (REP_N),
      .HOLD_W (HOLD_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .btn_raw_i   (btn_raw_i[i]),
      .grant_i     (grant_vec[i]),
      .btn_level_o (btn_level_o[i]),
      .pend_o      (pend[i]),
      .pend_rep_o  (pend_rep[i])
    );
  end

  // Rotate so bit 0 is the channel at rr_ptr; the lowest set bit is then the winner.
  always_comb begin
    rotated  = NBTN'({pend, pend} >> rr_ptr_q);
    any_pend = |pend;
    sel_off  = '0;
    for (int k = NBTN - 1; k >= 0; k--) begin
      if (rotated[k]) sel_off = ID_W'(k);
    end
    sum = {1'b0, rr_ptr_q} + {1'b0, sel_off};
    if (sum >= NBTN_W) sum = sum - NBTN_W;
    grant_id = sum[ID_W-1:0];
    nxt = {1'b0, grant_id} + 1'b1;
    if (nxt == NBTN_W) nxt = '0;
  end

  assign load = !valid_q || evt_if.evt_ready;

  always_comb begin
    valid_d   = valid_q;
    id_d      = id_q;
    rep_d     = rep_q;
    rr_ptr_d  = rr_ptr_q;
    grant_vec = '0;
    if (load) begin
      valid_d = any_pend;
      if (any_pend) begin
        id_d                = grant_id;
        rep_d               = pend_rep[grant_id];
        grant_vec[grant_id] = 1'b1;
        rr_ptr_d            = nxt[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      id_q     <= '0;
      rep_q    <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      id_q     <= id_d;
      rep_q    <= rep_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign evt_if.evt_valid  = valid_q;
  assign evt_if.evt_id     = id_q;
  assign evt_if.evt_repeat = rep_q;

endmodule
`default_nettype wire

// File: tb/tb_button_event_scheduler.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_button_event_scheduler: directed stimulus with a queued-expectation monitor. Rev 1.0
// -----------------------------------------------------------------------------
module tb_button_event_scheduler;
  import btn_pkg::*;

  localparam int NBTN   = 4;
  localparam int DEB_N  = 4;
  localparam int DEB_W  = 3;
  localparam int HOLD_N = 20;
  localparam int REP_N  = 8;
  localparam int HOLD_W = 5;
  localparam int ID_W   = 2;

  typedef struct {
    logic [ID_W-1:0] id;
    logic            rep;
    int              cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NBTN-1:0] btn_raw = '0;
  logic [NBTN-1:0] btn_level;
  int              cyc = 0;
  int              n_checks = 0;
  int              n_fail = 0;
  exp_t            exp_q[$];

  button_event_scheduler_if #(.ID_W(ID_W)) evt_if ();

  button_event_scheduler #(
    .NBTN   (NBTN),
    .DEB_N  (DEB_N),
    .DEB_W  (DEB_W),
    .HOLD_N (HOLD_N),
    .REP_N  (REP_N),
    .HOLD_W (HOLD_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw_i   (btn_raw),
    .btn_level_o (btn_level),
    .evt_if      (evt_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input int id, input bit rep, input int c);
    exp_t e;
    e.id  = ID_W'(id);
    e.rep = rep;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raw bits set now are first sampled on the next edge; level follows 6 edges later.
  task automatic press_pulse(input logic [NBTN-1:0] mask, input int hold);
    btn_raw = btn_raw | mask;
    tick(hold);
    btn_raw = btn_raw & ~mask;
    tick(10);
  endtask

  // Monitor: every handshake pops one expectation; a stalled event must not change.
  logic            prev_stall = 1'b0;
  logic [ID_W-1:0] prev_id = '0;
  logic            prev_rep = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (!(evt_if.evt_valid && evt_if.evt_id == prev_id && evt_if.evt_repeat == prev_rep)) begin
          n_fail++;
          $display("FAIL stall_hold cyc=%0d: got valid=%0b id=%0d rep=%0b, required valid=1 id=%0d rep=%0b",
                   cyc, evt_if.evt_valid, evt_if.evt_id, evt_if.evt_repeat, prev_id, prev_rep);
        end
      end
      if (evt_if.evt_valid && evt_if.evt_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got id=%0d rep=%0b cyc=%0d, required no event",
                   evt_if.evt_id, evt_if.evt_repeat, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (evt_if.evt_id !== e.id || evt_if.evt_repeat !== e.rep || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL event: got id=%0d rep=%0b cyc=%0d, required id=%0d rep=%0b cyc=%0d",
                     evt_if.evt_id, evt_if.evt_repeat, cyc, e.id, e.rep, e.cyc);
          end
        end
      end
      prev_stall = evt_if.evt_valid && !evt_if.evt_ready;
      prev_id    = evt_if.evt_id;
      prev_rep   = evt_if.evt_repeat;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [NBTN-1:0] lvl_or;
    evt_if.evt_ready = 1'b1;

    // Reset state
    tick(3);
    chk("rst_valid", 32'(evt_if.evt_valid), 0);
    chk("rst_id", 32'(evt_if.evt_id), 0);
    chk("rst_repeat", 32'(evt_if.evt_repeat), 0);
    chk("rst_level", 32'(btn_level), 0);
    rst = 1'b0;
    tick(2);

    // 1: short glitch never reaches the debounced level
    btn_raw[1] = 1'b1;
    tick(3);
    btn_raw[1] = 1'b0;
    lvl_or = '0;
    repeat (10) begin
      @(negedge clk);
      lvl_or = lvl_or | btn_level;
    end
    chk("glitch_level", 32'(lvl_or), 0);
    tick(1);

    // 2: single press, level edges exactly DEB_N+2 after the raw change
    k = cyc;
    push(2, 1'b0, k + 8);
    btn_raw[2] = 1'b1;
    tick(5);
    @(negedge clk);
    chk("press_level_before", 32'(btn_level[2]), 0);
    @(negedge clk);
    chk("press_level_after", 32'(btn_level[2]), 1);
    tick(4);
    btn_raw[2] = 1'b0;
    tick(5);
    @(negedge clk);
    chk("release_level_before", 32'(btn_level[2]), 1);
    @(negedge clk);
    chk("release_level_after", 32'(btn_level[2]), 0);
    tick(6);

    // 3: hold -> press, first repeat 20 later, then every 8
    k = cyc;
    push(0, 1'b0, k + 8);
    push(0, 1'b1, k + 28);
    push(0, 1'b1, k + 36);
    push(0, 1'b1, k + 44);
    push(0, 1'b1, k + 52);
    push(0, 1'b1, k + 60);
    press_pulse(4'b0001, 60);

    // 4: backpressure; second press waits in the slot, third is dropped
    evt_if.evt_ready = 1'b0;
    press_pulse(4'b1000, 8);
    chk("bp_valid", 32'(evt_if.evt_valid), 1);
    chk("bp_id", 32'(evt_if.evt_id), 3);
    press_pulse(4'b1000, 8);
    press_pulse(4'b1000, 8);
    k = cyc;
    push(3, 1'b0, k);
    push(3, 1'b0, k + 1);
    evt_if.evt_ready = 1'b1;
    tick(6);
    chk("bp_drained", 32'(evt_if.evt_valid), 0);

    // 5: simultaneous presses, rr_ptr = 0
    k = cyc;
    push(0, 1'b0, k + 8);
    push(1, 1'b0, k + 9);
    push(2, 1'b0, k + 10);
    push(3, 1'b0, k + 11);
    press_pulse(4'b1111, 8);
    // move rr_ptr to 2
    k = cyc;
    push(1, 1'b0, k + 8);
    press_pulse(4'b0010, 8);
    k = cyc;
    push(2, 1'b0, k + 8);
    push(3, 1'b0, k + 9);
    push(0, 1'b0, k + 10);
    push(1, 1'b0, k + 11);
    press_pulse(4'b1111, 8);

    // 6: reset while an event is stalled and the button is held
    evt_if.evt_ready = 1'b0;
    btn_raw[1] = 1'b1;
    tick(12);
    chk("pre_rst_valid", 32'(evt_if.evt_valid), 1);
    chk("pre_rst_id", 32'(evt_if.evt_id), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(evt_if.evt_valid), 0);
    chk("mid_rst_id", 32'(evt_if.evt_id), 0);
    chk("mid_rst_repeat", 32'(evt_if.evt_repeat), 0);
    chk("mid_rst_level", 32'(btn_level), 0);
    tick(2);
    rst = 1'b0;
    k = cyc;
    push(1, 1'b0, k + 8);
    evt_if.evt_ready = 1'b1;
    tick(12);
    btn_raw[1] = 1'b0;
    tick(12);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
